// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the seven-segment scan controller (SEG_SCAN_DEADTIME_EN adds BLANK)
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_SHOW  = 2'd1
`ifdef SEG_SCAN_DEADTIME_EN
        ,
        ST_BLANK = 2'd2
`endif
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {A,B,C,D,E,F,G} glyphs; leftmost entry is digit F, rightmost is digit 0.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    // One-hot active-low anode pattern for a digit index.
    function automatic logic [7:0] an_strobe(input logic [2:0] idx);
        return ~(8'd1 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - digit store write port bundle
interface seg_scan_ctrl_if;
    logic       write;
    logic [2:0] wsel;
    logic [3:0] num;

    modport master (output write, output wsel, output num);
    modport slave  (input  write, input  wsel, input  num);
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex digit to active-low seven-segment glyph
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup keeps the glyph set in one place, the package.
    always_comb begin
        seg = GLYPH_TABLE[digit];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit seven-segment refresh controller (optional dead time: SEG_SCAN_DEADTIME_EN)
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIV  = 100000,
    parameter int DEAD = 16
) (
    input  logic            clk,
    input  logic            reset,
    seg_scan_ctrl_if.slave  wr,
    input  logic            scan_en,
    output logic [7:0]      an,
    output logic [6:0]      seg,
    output logic [2:0]      slot
);

    localparam int             TW        = $clog2(DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
`ifdef SEG_SCAN_DEADTIME_EN
    localparam logic [TW-1:0]  DEAD_LAST = TW'(DEAD - 1);
`endif

    // Reject parameter sets that would break the slot timing.
    if (DIV < 4 || DEAD >= DIV) begin : g_bad_param
        $error("seg_scan_ctrl: need DIV >= 4 and DEAD < DIV");
    end

    logic [7:0][3:0] mem;
    logic [TW-1:0]   tick;
    logic [TW-1:0]   tick_nxt;
    logic [2:0]      slot_nxt;
    scan_state_t     state;
    scan_state_t     state_nxt;
    logic [7:0]      an_nxt;
    logic [6:0]      seg_nxt;
    logic [6:0]      dec_seg;

    // Digit store: one write per cycle, cleared by reset which also wins over a write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem <= '0;
        end else if (wr.write) begin
            mem[wr.wsel] <= wr.num;
        end
    end

    // Glyph of the digit that will be strobed after this edge; store reads pre-write,
    // so a fresh write shows up one edge after it lands.
    seg7_decode u_decode (
        .digit (mem[slot_nxt]),
        .seg   (dec_seg)
    );

    // Prescaler, slot counter and scan state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RESET;
            tick  <= '0;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            tick  <= tick_nxt;
            slot  <= slot_nxt;
        end
    end

    // Next-state logic; the edge leaving RESET does not count so the first slot is a full DIV.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        slot_nxt  = slot;
        if (scan_en) begin
            if (state != ST_RESET) begin
                if (tick == TICK_LAST) begin
                    tick_nxt = '0;
                    slot_nxt = slot + 3'd1;
                end else begin
                    tick_nxt = tick + 1'b1;
                end
            end
            case (state)
                ST_RESET: begin
`ifdef SEG_SCAN_DEADTIME_EN
                    state_nxt = ST_BLANK;
`else
                    state_nxt = ST_SHOW;
`endif
                end
                ST_SHOW: begin
`ifdef SEG_SCAN_DEADTIME_EN
                    if (tick == TICK_LAST) begin
                        state_nxt = ST_BLANK;
                    end
`else
                    state_nxt = ST_SHOW;
`endif
                end
`ifdef SEG_SCAN_DEADTIME_EN
                ST_BLANK: begin
                    if (tick == DEAD_LAST) begin
                        state_nxt = ST_SHOW;
                    end
                end
`endif
                default: state_nxt = ST_RESET;
            endcase
        end
    end

    // Output pattern follows the post-edge state; a disabled scan always blanks.
    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        if (scan_en && state_nxt == ST_SHOW) begin
            an_nxt  = an_strobe(slot_nxt);
            seg_nxt = dec_seg;
        end
    end

    // Registered display pins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with a cycle-count display model
module tb_seg_scan_ctrl;

    localparam int DIV  = 8;
    localparam int DEAD = 2;
`ifdef SEG_SCAN_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       scan_en;
    logic [7:0] an;
    logic [6:0] seg;
    logic [2:0] slot;

    seg_scan_ctrl_if wif ();

    seg_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wif),
        .scan_en (scan_en),
        .an      (an),
        .seg     (seg),
        .slot    (slot)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Model: the display is a function of the number of enabled cycles since release.
    logic       model_live = 1'b0;
    bit         m_started;
    int         m_cnt;
    logic [3:0] m_mem [8];
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic [2:0] exp_slot;

    always @(posedge clk) begin : model
        int c;
        int sl;
        int tk;
        bit sh;
        model_live <= 1'b1;
        if (!reset) begin
            m_started <= 1'b0;
            m_cnt     <= 0;
            for (int i = 0; i < 8; i++) m_mem[i] <= 4'h0;
            exp_an    <= 8'hFF;
            exp_seg   <= 7'h7F;
            exp_slot  <= 3'd0;
        end else begin
            c = m_cnt;
            if (scan_en && m_started) c = c + 1;
            if (scan_en) m_started <= 1'b1;
            sl = (c / DIV) % 8;
            tk = c % DIV;
            sh = scan_en && (!DT || tk >= DEAD);
            m_cnt    <= c;
            exp_slot <= 3'(sl);
            exp_an   <= sh ? ~(8'd1 << sl) : 8'hFF;
            exp_seg  <= sh ? glyph(m_mem[sl]) : 7'h7F;
            if (wif.write) m_mem[wif.wsel] <= wif.num;
        end
    end

    // Every-cycle comparison of the pins against the model.
    always @(negedge clk) begin
        if (model_live) begin
            check("model_an", {24'd0, an}, {24'd0, exp_an});
            check("model_seg", {25'd0, seg}, {25'd0, exp_seg});
            check("model_slot", {29'd0, slot}, {29'd0, exp_slot});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        scan_en   = 1'b1;
        wif.write = 1'b1;
        wif.wsel  = 3'd5;
        wif.num   = 4'h9;
        step(3);
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_slot", {29'd0, slot}, 32'd0);

        reset     = 1'b1;
        wif.write = 1'b0;
        step(1);
        check("first_an", {24'd0, an}, DT ? 32'hFF : 32'hFE);
        check("first_seg", {25'd0, seg}, DT ? 32'h7F : 32'b0000001);

        wif.write = 1'b1;
        wif.wsel  = 3'd3;
        wif.num   = 4'hA;
        step(1);
        wif.write = 1'b0;
        step(27);
        check("s3_an", {24'd0, an}, 32'b11110111);
        check("s3_seg_a", {25'd0, seg}, 32'b0001000);

        wif.write = 1'b1;
        wif.wsel  = 3'd3;
        wif.num   = 4'h5;
        step(1);
        wif.write = 1'b0;
        check("s3_seg_old", {25'd0, seg}, 32'b0001000);
        step(1);
        check("s3_seg_new", {25'd0, seg}, 32'b0100100);

        step(30);
        check("s7_an", {24'd0, an}, 32'b01111111);
        check("s7_slot", {29'd0, slot}, 32'd7);
        step(3);
        check("s7_last_slot", {29'd0, slot}, 32'd7);
        step(1);
        check("wrap_slot", {29'd0, slot}, 32'd0);
        check("wrap_an", {24'd0, an}, DT ? 32'hFF : 32'hFE);

        step(20);
        scan_en = 1'b0;
        step(1);
        check("gap_an", {24'd0, an}, 32'hFF);
        check("gap_seg", {25'd0, seg}, 32'h7F);
        check("gap_slot", {29'd0, slot}, 32'd2);
        step(4);
        check("gap_end_an", {24'd0, an}, 32'hFF);
        scan_en = 1'b1;
        step(1);
        check("resume_an", {24'd0, an}, 32'b11111011);
        check("resume_slot", {29'd0, slot}, 32'd2);
        step(2);
        check("resume_last_slot", {29'd0, slot}, 32'd2);
        step(1);
        check("resume_next_slot", {29'd0, slot}, 32'd3);

        wif.write = 1'b1;
        wif.wsel  = 3'd0;
        wif.num   = 4'h7;
        step(1);
        wif.write = 1'b0;
        step(28);
        check("pre_rst_slot", {29'd0, slot}, 32'd6);

        reset     = 1'b0;
        wif.write = 1'b1;
        wif.wsel  = 3'd6;
        wif.num   = 4'hF;
        step(1);
        check("midrst_an", {24'd0, an}, 32'hFF);
        check("midrst_seg", {25'd0, seg}, 32'h7F);
        check("midrst_slot", {29'd0, slot}, 32'd0);
        reset     = 1'b1;
        wif.write = 1'b0;
        step(3);
        check("restart_an", {24'd0, an}, 32'hFE);
        check("restart_seg", {25'd0, seg}, 32'b0000001);
        step(50);
        check("cleared6_an", {24'd0, an}, 32'b10111111);
        check("cleared6_seg", {25'd0, seg}, 32'b0000001);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
